// File: rtl/bw_clk_fdbk_mon_pkg.sv
// rtl/bw_clk_fdbk_mon_pkg.sv - shared types and default sizes for the feedback-clock lock monitor
package bw_clk_fdbk_mon_pkg;

  localparam int CW_DEF         = 10;
  localparam int ECW_DEF        = 8;
  localparam int LOCK_CNT_DEF   = 8;
  localparam int UNLOCK_CNT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } mon_state_e;

endpackage

// File: rtl/bw_clk_gl_fdbk_mon_if.sv
// rtl/bw_clk_gl_fdbk_mon_if.sv - control/status bundle of the feedback-clock lock monitor
interface bw_clk_gl_fdbk_mon_if #(
  parameter int CW  = 10,
  parameter int ECW = 8
);
  logic           fdbk_tgl;
  logic           enable;
  logic [CW-1:0]  cfg_ratio;
  logic [CW-1:0]  cfg_tol;
  logic           lost_clr;
  logic           lock;
  logic           lock_lost;
  logic [CW-1:0]  period;
  logic           period_vld;
  logic [ECW-1:0] err_cnt;

  modport mon (
    input  fdbk_tgl, enable, cfg_ratio, cfg_tol, lost_clr,
    output lock, lock_lost, period, period_vld, err_cnt
  );

  modport ctl (
    output fdbk_tgl, enable, cfg_ratio, cfg_tol, lost_clr,
    input  lock, lock_lost, period, period_vld, err_cnt
  );
endinterface

// File: rtl/bw_clk_fdbk_sync.sv
// rtl/bw_clk_fdbk_sync.sv - brings the feedback toggle into gclk and flags each of its transitions
module bw_clk_fdbk_sync (
  input  logic gclk,
  input  logic arst_l,
  input  logic fdbk_tgl,
  output logic tgl_edge
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= fdbk_tgl;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tgl_edge = s2_q ^ s3_q;

endmodule

// File: rtl/bw_clk_gl_fdbk_mon.sv
// rtl/bw_clk_gl_fdbk_mon.sv - measures the feedback toggle period in gclk cycles and tracks lock
module bw_clk_gl_fdbk_mon
  import bw_clk_fdbk_mon_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int ECW        = ECW_DEF
) (
  input  logic           gclk,
  input  logic           arst_l,
  input  logic           fdbk_tgl,
  input  logic           enable,
  input  logic [CW-1:0]  cfg_ratio,
  input  logic [CW-1:0]  cfg_tol,
  input  logic           lost_clr,
  output logic           lock,
  output logic           lock_lost,
  output logic [CW-1:0]  period,
  output logic           period_vld,
  output logic [ECW-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};
  localparam logic [ECW-1:0] ERR_MAX = {ECW{1'b1}};

  mon_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           first_q, first_d;
  logic           to_flag_q, to_flag_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic [BW-1:0]  bad_cnt_q, bad_cnt_d;
  logic [CW-1:0]  period_q, period_d;
  logic           period_vld_q, period_vld_d;
  logic           lock_lost_q, lock_lost_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  logic           tgl_edge;
  logic           active, sat, timeout, evaluate, good, good_evt, bad_evt, loss_evt;
  logic [CW:0]    diff;

  bw_clk_fdbk_sync u_sync (
    .gclk     (gclk),
    .arst_l   (arst_l),
    .fdbk_tgl (fdbk_tgl),
    .tgl_edge (tgl_edge)
  );

  // Timeout fires once per saturation episode; the flag is rearmed by the next edge.
  assign active   = enable && (state_q != ST_IDLE);
  assign sat      = (cnt_q == CNT_MAX);
  assign timeout  = active && sat && !tgl_edge && !to_flag_q;
  assign evaluate = active && tgl_edge && !first_q;
  assign diff     = ({1'b0, cnt_q} >= {1'b0, cfg_ratio}) ? ({1'b0, cnt_q} - {1'b0, cfg_ratio})
                                                         : ({1'b0, cfg_ratio} - {1'b0, cnt_q});
  assign good     = (diff <= {1'b0, cfg_tol});
  assign good_evt = evaluate && good;
  assign bad_evt  = (evaluate && !good) || timeout;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    to_flag_d    = to_flag_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    loss_evt     = 1'b0;
    if (!active) begin
      state_d    = enable ? ST_ACQ : ST_IDLE;
      cnt_d      = '0;
      first_d    = 1'b1;
      to_flag_d  = 1'b0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      if (tgl_edge) begin
        cnt_d     = {{(CW-1){1'b0}}, 1'b1};
        first_d   = 1'b0;
        to_flag_d = 1'b0;
        if (!first_q) begin
          period_d     = cnt_q;
          period_vld_d = 1'b1;
        end
      end else if (!sat) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        to_flag_d = 1'b1;
      end
      case (state_q)
        ST_ACQ: begin
          if (good_evt) begin
            if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else if (bad_evt) begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (timeout || (bad_evt && (bad_cnt_q == BW'(UNLOCK_CNT - 1)))) begin
            state_d   = ST_LOST;
            loss_evt  = 1'b1;
            bad_cnt_d = '0;
          end else if (bad_evt) begin
            bad_cnt_d = bad_cnt_q + 1'b1;
          end else if (good_evt) begin
            bad_cnt_d = '0;
          end
        end
        ST_LOST: begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A same-cycle loss or error wins over lost_clr.
  assign lock_lost_d = loss_evt || (lock_lost_q && !lost_clr);
  assign err_cnt_d   = lost_clr ? {{(ECW-1){1'b0}}, bad_evt}
                     : ((bad_evt && (err_cnt_q != ERR_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q);

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      to_flag_q    <= 1'b0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      to_flag_q    <= to_flag_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      lock_lost_q  <= lock_lost_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign lock       = (state_q == ST_LOCKED);
  assign lock_lost  = lock_lost_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bw_clk_gl_fdbk_mon.sv
// tb/tb_bw_clk_gl_fdbk_mon.sv - directed self-checking bench for the feedback-clock lock monitor
module tb_bw_clk_gl_fdbk_mon;
  import bw_clk_fdbk_mon_pkg::*;

  logic gclk   = 1'b0;
  logic arst_l = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   vld_cnt   = 0;
  int   since_tgl = 0;

  always #5 gclk = ~gclk;

  bw_clk_gl_fdbk_mon_if #(.CW(10), .ECW(8)) ifc ();

  bw_clk_gl_fdbk_mon dut (
    .gclk       (gclk),
    .arst_l     (arst_l),
    .fdbk_tgl   (ifc.fdbk_tgl),
    .enable     (ifc.enable),
    .cfg_ratio  (ifc.cfg_ratio),
    .cfg_tol    (ifc.cfg_tol),
    .lost_clr   (ifc.lost_clr),
    .lock       (ifc.lock),
    .lock_lost  (ifc.lock_lost),
    .period     (ifc.period),
    .period_vld (ifc.period_vld),
    .err_cnt    (ifc.err_cnt)
  );

  task automatic cyc();
    @(posedge gclk);
    #1;
    since_tgl++;
    if (ifc.period_vld === 1'b1) vld_cnt++;
  endtask

  task automatic flip();
    ifc.fdbk_tgl = ~ifc.fdbk_tgl;
    since_tgl = 0;
  endtask

  task automatic first_edge();
    flip();
    repeat (3) cyc();
  endtask

  // Toggles per cycles after the previous toggle; returns on the cycle its period_vld is visible.
  task automatic man_edge(input int per, input bit clr);
    while (since_tgl < per) cyc();
    flip();
    cyc();
    cyc();
    ifc.lost_clr = clr;
    cyc();
    ifc.lost_clr = 1'b0;
  endtask

  task automatic test_reset();
    ifc.enable = 1'b1;
    repeat (6) begin
      flip();
      cyc();
      cyc();
    end
    n_cmp++; if (ifc.lock !== 1'b0) begin n_err++; $display("FAIL rst_lock: got %0b want 0", ifc.lock); end
    n_cmp++; if (ifc.lock_lost !== 1'b0) begin n_err++; $display("FAIL rst_lock_lost: got %0b want 0", ifc.lock_lost); end
    n_cmp++; if (ifc.period !== 10'd0) begin n_err++; $display("FAIL rst_period: got %0d want 0", ifc.period); end
    n_cmp++; if (ifc.period_vld !== 1'b0) begin n_err++; $display("FAIL rst_period_vld: got %0b want 0", ifc.period_vld); end
    n_cmp++; if (ifc.err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err_cnt: got %0d want 0", ifc.err_cnt); end
    n_cmp++; if (vld_cnt !== 0) begin n_err++; $display("FAIL rst_no_vld: got %0d want 0", vld_cnt); end
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    ifc.enable = 1'b0;
    arst_l = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_acquire();
    ifc.enable = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (dut.state_q !== ST_ACQ) begin n_err++; $display("FAIL acq_state: got %0d want %0d", dut.state_q, ST_ACQ); end
    first_edge();
    n_cmp++; if (vld_cnt !== 0) begin n_err++; $display("FAIL acq_discard: got %0d want 0", vld_cnt); end
    for (int i = 1; i <= 8; i++) begin
      man_edge(16, 1'b0);
      n_cmp++; if (ifc.period_vld !== 1'b1) begin n_err++; $display("FAIL acq_vld[%0d]: got %0b want 1", i, ifc.period_vld); end
      n_cmp++; if (ifc.period !== 10'd16) begin n_err++; $display("FAIL acq_period[%0d]: got %0d want 16", i, ifc.period); end
      n_cmp++; if (ifc.lock !== (i == 8)) begin n_err++; $display("FAIL acq_lock[%0d]: got %0b want %0b", i, ifc.lock, (i == 8)); end
    end
    n_cmp++; if (ifc.err_cnt !== 8'd0) begin n_err++; $display("FAIL acq_err_cnt: got %0d want 0", ifc.err_cnt); end
  endtask

  task automatic test_drift();
    man_edge(20, 1'b0);
    n_cmp++; if (ifc.period !== 10'd20) begin n_err++; $display("FAIL drift_period: got %0d want 20", ifc.period); end
    n_cmp++; if (ifc.lock !== 1'b1) begin n_err++; $display("FAIL drift_lock1: got %0b want 1", ifc.lock); end
    n_cmp++; if (ifc.err_cnt !== 8'd1) begin n_err++; $display("FAIL drift_err1: got %0d want 1", ifc.err_cnt); end
    man_edge(20, 1'b0);
    n_cmp++; if (ifc.lock !== 1'b0) begin n_err++; $display("FAIL drift_lock2: got %0b want 0", ifc.lock); end
    n_cmp++; if (ifc.lock_lost !== 1'b1) begin n_err++; $display("FAIL drift_lost: got %0b want 1", ifc.lock_lost); end
    n_cmp++; if (ifc.err_cnt !== 8'd2) begin n_err++; $display("FAIL drift_err2: got %0d want 2", ifc.err_cnt); end
    n_cmp++; if (dut.state_q !== ST_LOST) begin n_err++; $display("FAIL drift_state_lost: got %0d want %0d", dut.state_q, ST_LOST); end
    cyc();
    n_cmp++; if (dut.state_q !== ST_ACQ) begin n_err++; $display("FAIL drift_state_acq: got %0d want %0d", dut.state_q, ST_ACQ); end
    for (int i = 1; i <= 8; i++) begin
      man_edge(16, 1'b0);
      n_cmp++; if (ifc.lock !== (i == 8)) begin n_err++; $display("FAIL relock[%0d]: got %0b want %0b", i, ifc.lock, (i == 8)); end
    end
    n_cmp++; if (ifc.err_cnt !== 8'd2) begin n_err++; $display("FAIL relock_err: got %0d want 2", ifc.err_cnt); end
  endtask

  task automatic test_timeout();
    int v0;
    ifc.lost_clr = 1'b1;
    cyc();
    ifc.lost_clr = 1'b0;
    n_cmp++; if (ifc.lock_lost !== 1'b0) begin n_err++; $display("FAIL clr_lost: got %0b want 0", ifc.lock_lost); end
    n_cmp++; if (ifc.err_cnt !== 8'd0) begin n_err++; $display("FAIL clr_err: got %0d want 0", ifc.err_cnt); end
    v0 = vld_cnt;
    while (since_tgl < 1025) cyc();
    n_cmp++; if (ifc.lock !== 1'b1) begin n_err++; $display("FAIL to_lock_before: got %0b want 1", ifc.lock); end
    cyc();
    n_cmp++; if (ifc.lock !== 1'b0) begin n_err++; $display("FAIL to_lock_after: got %0b want 0", ifc.lock); end
    n_cmp++; if (ifc.lock_lost !== 1'b1) begin n_err++; $display("FAIL to_lost: got %0b want 1", ifc.lock_lost); end
    n_cmp++; if (ifc.err_cnt !== 8'd1) begin n_err++; $display("FAIL to_err: got %0d want 1", ifc.err_cnt); end
    repeat (100) cyc();
    n_cmp++; if (ifc.err_cnt !== 8'd1) begin n_err++; $display("FAIL to_err_once: got %0d want 1", ifc.err_cnt); end
    n_cmp++; if (dut.cnt_q !== 10'd1023) begin n_err++; $display("FAIL to_cnt_sat: got %0d want 1023", dut.cnt_q); end
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL to_no_vld: got %0d want %0d", vld_cnt, v0); end
    n_cmp++; if (ifc.period !== 10'd16) begin n_err++; $display("FAIL to_period: got %0d want 16", ifc.period); end
  endtask

  task automatic test_enable();
    int v0;
    ifc.enable = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL dis_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if (ifc.lock_lost !== 1'b1) begin n_err++; $display("FAIL dis_lost_kept: got %0b want 1", ifc.lock_lost); end
    n_cmp++; if (ifc.err_cnt !== 8'd1) begin n_err++; $display("FAIL dis_err_kept: got %0d want 1", ifc.err_cnt); end
    n_cmp++; if (dut.cnt_q !== 10'd0) begin n_err++; $display("FAIL dis_cnt: got %0d want 0", dut.cnt_q); end
    ifc.lost_clr = 1'b1;
    cyc();
    ifc.lost_clr = 1'b0;
    ifc.enable = 1'b1;
    cyc();
    cyc();
    first_edge();
    repeat (5) man_edge(16, 1'b0);
    n_cmp++; if (dut.good_cnt_q !== 4'd5) begin n_err++; $display("FAIL en_good5: got %0d want 5", dut.good_cnt_q); end
    ifc.enable = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (dut.good_cnt_q !== 4'd0) begin n_err++; $display("FAIL en_good_clr: got %0d want 0", dut.good_cnt_q); end
    n_cmp++; if (ifc.lock !== 1'b0) begin n_err++; $display("FAIL en_lock0: got %0b want 0", ifc.lock); end
    ifc.enable = 1'b1;
    cyc();
    cyc();
    v0 = vld_cnt;
    first_edge();
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL en_discard: got %0d want %0d", vld_cnt, v0); end
    for (int i = 1; i <= 8; i++) begin
      man_edge(16, 1'b0);
      n_cmp++; if (ifc.lock !== (i == 8)) begin n_err++; $display("FAIL en_relock[%0d]: got %0b want %0b", i, ifc.lock, (i == 8)); end
    end
    n_cmp++; if (ifc.err_cnt !== 8'd0) begin n_err++; $display("FAIL en_err: got %0d want 0", ifc.err_cnt); end
    @(posedge gclk);
    #1;
    arst_l = 1'b0;
    #1;
    n_cmp++; if (ifc.lock !== 1'b0) begin n_err++; $display("FAIL arst_lock: got %0b want 0", ifc.lock); end
    n_cmp++; if (ifc.period !== 10'd0) begin n_err++; $display("FAIL arst_period: got %0d want 0", ifc.period); end
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL arst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    cyc();
    cyc();
    arst_l = 1'b1;
    cyc();
  endtask

  task automatic test_collisions();
    ifc.enable = 1'b0;
    repeat (4) cyc();
    ifc.enable = 1'b1;
    cyc();
    cyc();
    first_edge();
    repeat (8) man_edge(16, 1'b0);
    n_cmp++; if (ifc.lock !== 1'b1) begin n_err++; $display("FAIL col_lock: got %0b want 1", ifc.lock); end
    man_edge(20, 1'b0);
    man_edge(20, 1'b1);
    n_cmp++; if (ifc.lock_lost !== 1'b1) begin n_err++; $display("FAIL col_lost_wins: got %0b want 1", ifc.lock_lost); end
    n_cmp++; if (ifc.err_cnt !== 8'd1) begin n_err++; $display("FAIL col_err_loss: got %0d want 1", ifc.err_cnt); end
    ifc.lost_clr = 1'b1;
    cyc();
    ifc.lost_clr = 1'b0;
    man_edge(20, 1'b0);
    man_edge(20, 1'b0);
    n_cmp++; if (ifc.err_cnt !== 8'd2) begin n_err++; $display("FAIL col_err2: got %0d want 2", ifc.err_cnt); end
    man_edge(20, 1'b1);
    n_cmp++; if (ifc.err_cnt !== 8'd1) begin n_err++; $display("FAIL col_err_bad: got %0d want 1", ifc.err_cnt); end
    n_cmp++; if (ifc.lock_lost !== 1'b0) begin n_err++; $display("FAIL col_lost_clr: got %0b want 0", ifc.lock_lost); end
    for (int i = 0; i < 300; i++) begin
      man_edge(4, 1'b0);
      if (i == 252) begin
        n_cmp++; if (ifc.err_cnt !== 8'd254) begin n_err++; $display("FAIL sat_err254: got %0d want 254", ifc.err_cnt); end
      end
    end
    n_cmp++; if (ifc.period !== 10'd4) begin n_err++; $display("FAIL sat_period: got %0d want 4", ifc.period); end
    n_cmp++; if (ifc.err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_err255: got %0d want 255", ifc.err_cnt); end
  endtask

  initial begin
    ifc.fdbk_tgl  = 1'b0;
    ifc.enable    = 1'b0;
    ifc.cfg_ratio = 10'd16;
    ifc.cfg_tol   = 10'd1;
    ifc.lost_clr  = 1'b0;
    test_reset();
    test_acquire();
    test_drift();
    test_timeout();
    test_enable();
    test_collisions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
